fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem requests, instruction FIFO and redirect flush.
// Optional macro FETCH_MISALIGN_FAULT_EN: a misaligned redirect raises fetch_fault and halts fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_MISALIGN_FAULT_EN
    ,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(MAX_OUTSTANDING - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [OUT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0] inst_mem [FIFO_DEPTH];
    logic [31:0] ipc_mem  [FIFO_DEPTH];
    logic [31:0] tag_mem  [MAX_OUTSTANDING];

    logic fire, rv, rv_drop, push, pop, credit, halt_d;

    assign fire    = req_q && imem_gnt;
    // Responses with nothing outstanding are protocol errors and never touch state.
    assign rv      = imem_rvalid && (outst_q != '0);
    assign rv_drop = rv && (drop_q != '0);
    assign push    = rv && (drop_q == '0) && !redirect_valid;
    assign pop     = (count_q != '0) && inst_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_d     = pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;

        if (fire) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TAG_W'(1);
        end
        if (rv) tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TAG_W'(1);

        if (fire && !rv)      outst_d = outst_q + OUT_W'(1);
        else if (!fire && rv) outst_d = outst_q - OUT_W'(1);
        if (rv_drop) drop_d = drop_q - OUT_W'(1);

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        // Everything still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            pc_d     = redirect_pc & ~32'h3;
            drop_d   = outst_d;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        credit = (32'(outst_d) < MAX_OUTSTANDING) &&
                 ((32'(count_d) + 32'(outst_d) - 32'(drop_d)) < FIFO_DEPTH);

        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (!credit) state_d = S_STALL;
            S_STALL: if (credit || redirect_valid) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_FETCH) && credit && !redirect_valid && !halt_d;
        addr_d = pc_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (fire) tag_mem[tag_wr_q] <= pc_q;
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata;
            ipc_mem[wr_ptr_q]  <= tag_mem[tag_rd_q];
        end
    end

`ifdef FETCH_MISALIGN_FAULT_EN
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    always_comb begin
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
            if (redirect_pc[1:0] != 2'b00) fault_pc_d = redirect_pc;
        end
    end

    assign halt_d = fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
`else
    assign halt_d = 1'b0;
`endif

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? inst_mem[rd_ptr_q] : NOP;
    assign inst_pc    = inst_valid ? ipc_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized imem/decoder behaviour against a program-order PC model.
// Build with FETCH_MISALIGN_FAULT_EN defined to also exercise the fault ports.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef FETCH_MISALIGN_FAULT_EN
    logic        fetch_fault;
    logic [31:0] fault_pc;
`endif

    fetch_unit #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_MISALIGN_FAULT_EN
        ,
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int gnt_pct = 100;
    int rv_pct  = 100;
    int rdy_pct = 100;

    // Memory model state and program-order reference model.
    logic [31:0] pend_q[$];
    logic [31:0] grant_addrs[$];
    int          grant_cyc[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc;
    int          pops;
    int          cyc;
    bit          chk_empty_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_clear();
        pend_q.delete();
        grant_addrs.delete();
        grant_cyc.delete();
        pop_log.delete();
        exp_pc = RESET_PC;
        pops = 0;
        cyc = 0;
        chk_empty_next = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: entered and left at a negedge.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit g, rv;
        rv = (pend_q.size() > 0) && ($urandom_range(99) < rv_pct);
        g  = ($urandom_range(99) < gnt_pct);
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pend_q[0]) : $urandom();
        imem_gnt       = g;
        inst_ready     = ($urandom_range(99) < rdy_pct);
        redirect_valid = redir;
        redirect_pc    = rpc;

        if (chk_empty_next) begin
            tests_run++;
            if (inst_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush: inst_valid=%b after redirect, required 0", inst_valid);
            end
            chk_empty_next = 1'b0;
        end

        if (inst_valid === 1'b1 && inst_ready) begin
            tests_run++;
            if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                tests_failed++;
                $display("FAIL deliver: pc=%h inst=%h, required pc=%h inst=%h",
                         inst_pc, inst, exp_pc, mem_word(exp_pc));
            end
            pop_log.push_back(inst_pc);
            pops++;
            exp_pc = exp_pc + 32'd4;
        end

        if (rv) void'(pend_q.pop_front());
        if (imem_req === 1'b1 && g) begin
            pend_q.push_back(imem_addr);
            grant_addrs.push_back(imem_addr);
            grant_cyc.push_back(cyc);
            tests_run++;
            if (pend_q.size() > MAX_OUT || imem_addr[1:0] !== 2'b00) begin
                tests_failed++;
                $display("FAIL grant: outstanding=%0d addr=%h, required <=%0d and aligned",
                         pend_q.size(), imem_addr, MAX_OUT);
            end
        end

        @(posedge clk);
        if (redir) begin
            exp_pc = rpc & ~32'h3;
            chk_empty_next = 1'b1;
        end
        cyc++;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic run_until_pops(input int target, input int budget, input string tag);
        int n = 0;
        while (pops < target && n < budget) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        tests_run++;
        if (pops < target) begin
            tests_failed++;
            $display("FAIL %s: timeout with %0d delivered, required %0d", tag, pops, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        model_clear();
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_vals: req=%b addr=%h iv=%b inst=%h ipc=%h, required 0 %h 0 00000013 0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, RESET_PC);
        end
`ifdef FETCH_MISALIGN_FAULT_EN
        tests_run++;
        if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_fault: fault=%b pc=%h, required 0 0", fetch_fault, fault_pc);
        end
`endif
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_req: req=%b, required 0", imem_req);
        end
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        run_until_pops(3, 40, "stream");
        tests_run++;
        if (grant_addrs.size() < 3) begin
            tests_failed++;
            $display("FAIL stream_grants: %0d grants, required >=3", grant_addrs.size());
        end else begin
            tests_run++;
            if (grant_addrs[0] !== 32'h0 || grant_addrs[1] !== 32'h4 || grant_addrs[2] !== 32'h8) begin
                tests_failed++;
                $display("FAIL stream_addrs: %h %h %h, required 0 4 8",
                         grant_addrs[0], grant_addrs[1], grant_addrs[2]);
            end
            tests_run++;
            if (grant_cyc[1] !== grant_cyc[0] + 1) begin
                tests_failed++;
                $display("FAIL stream_b2b: cycles %0d %0d, required consecutive", grant_cyc[0], grant_cyc[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        run_until_pops(2, 40, "bp_warm");
        rdy_pct = 0;
        repeat (10) cycle(1'b0, 32'h0);
        tests_run++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0 || pend_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_full: iv=%b req=%b outstanding=%0d, required 1 0 0",
                     inst_valid, imem_req, pend_q.size());
        end
        rdy_pct = 100;
        run_until_pops(pops + 6, 60, "bp_resume");
    endtask

    task automatic test_redirect_outstanding();
        int n = 0;
        int p0;
        do_reset();
        gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
        while (pend_q.size() < 2 && n < 10) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        tests_run++;
        if (pend_q.size() != 2) begin
            tests_failed++;
            $display("FAIL redir_setup: outstanding=%0d, required 2", pend_q.size());
        end
        cycle(1'b1, 32'h100);
        p0 = pops;
        rv_pct = 100;
        run_until_pops(p0 + 3, 40, "redir_out");
        tests_run++;
        if (pop_log.size() <= p0 || pop_log[p0] !== 32'h100) begin
            tests_failed++;
            $display("FAIL redir_first: first pc=%h, required 00000100",
                     (pop_log.size() > p0) ? pop_log[p0] : 32'hx);
        end
    endtask

    task automatic test_redirect_collision();
        int n = 0;
        int p0;
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        while (!(imem_req === 1'b1 && pend_q.size() > 0) && n < 10) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        tests_run++;
        if (!(imem_req === 1'b1 && pend_q.size() > 0)) begin
            tests_failed++;
            $display("FAIL coll_setup: req=%b outstanding=%0d, required 1 and >0", imem_req, pend_q.size());
        end
        cycle(1'b1, 32'h300);
        p0 = pops;
        run_until_pops(p0 + 3, 40, "coll");
        tests_run++;
        if (pop_log.size() <= p0 || pop_log[p0] !== 32'h300) begin
            tests_failed++;
            $display("FAIL coll_first: first pc=%h, required 00000300",
                     (pop_log.size() > p0) ? pop_log[p0] : 32'hx);
        end
    endtask

    task automatic test_grant_stall();
        do_reset();
        gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
        cycle(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                tests_failed++;
                $display("FAIL hold_%0d: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, RESET_PC);
            end
            cycle(1'b0, 32'h0);
        end
        gnt_pct = 100;
        run_until_pops(2, 30, "hold_resume");
        tests_run++;
        if (grant_addrs.size() == 0 || grant_addrs[0] !== RESET_PC) begin
            tests_failed++;
            $display("FAIL hold_first: %0d grants, required first at %h", grant_addrs.size(), RESET_PC);
        end
    endtask

    task automatic test_wrap();
        int p0;
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        cycle(1'b1, 32'hFFFF_FFF8);
        p0 = pops;
        run_until_pops(p0 + 4, 40, "wrap");
        tests_run++;
        if (pop_log.size() < p0 + 3 || pop_log[p0 + 2] !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_pc: third pc after redirect=%h, required 00000000",
                     (pop_log.size() >= p0 + 3) ? pop_log[p0 + 2] : 32'hx);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        gnt_pct = 60; rv_pct = 50; rdy_pct = 70;
        repeat (20) cycle(1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL midreset: req=%b iv=%b addr=%h, required 0 0 %h",
                     imem_req, inst_valid, imem_addr, RESET_PC);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_rvalid: iv=%b, required 0", inst_valid);
        end
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        run_until_pops(2, 30, "post_reset");
        tests_run++;
        if (pop_log.size() == 0 || pop_log[0] !== RESET_PC) begin
            tests_failed++;
            $display("FAIL post_reset_pc: first pc=%h, required %h",
                     (pop_log.size() > 0) ? pop_log[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            gnt_pct = $urandom_range(100, 20);
            rv_pct  = $urandom_range(100, 20);
            rdy_pct = $urandom_range(100, 10);
            for (int i = 0; i < 100; i++) begin
                rpc = $urandom() & 32'h0000_3FFF;
`ifdef FETCH_MISALIGN_FAULT_EN
                rpc = rpc & ~32'h3;
`endif
                cycle($urandom_range(99) < 4, rpc);
            end
        end
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        run_until_pops(pops + 4, 100, "random_drain");
    endtask

`ifdef FETCH_MISALIGN_FAULT_EN
    task automatic test_fault();
        int p0;
        do_reset();
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        run_until_pops(2, 30, "fault_warm");
        cycle(1'b1, 32'h102);
        tests_run++;
        if (fetch_fault !== 1'b1 || fault_pc !== 32'h102 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_set: fault=%b pc=%h req=%b, required 1 00000102 0",
                     fetch_fault, fault_pc, imem_req);
        end
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0);
            tests_run++;
            if (imem_req !== 1'b0 || fetch_fault !== 1'b1) begin
                tests_failed++;
                $display("FAIL fault_halt_%0d: req=%b fault=%b, required 0 1", i, imem_req, fetch_fault);
            end
        end
        tests_run++;
        if (pops != p0) begin
            tests_failed++;
            $display("FAIL fault_nodeliver: %0d delivered, required 0", pops - p0);
        end
        cycle(1'b1, 32'h200);
        tests_run++;
        if (fetch_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_clear: fault=%b, required 0", fetch_fault);
        end
        p0 = pops;
        run_until_pops(p0 + 2, 30, "fault_resume");
        tests_run++;
        if (pop_log.size() <= p0 || pop_log[p0] !== 32'h200) begin
            tests_failed++;
            $display("FAIL fault_resume_pc: first pc=%h, required 00000200",
                     (pop_log.size() > p0) ? pop_log[p0] : 32'hx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_collision();
        test_grant_stall();
        test_wrap();
        test_midreset();
        test_random();
`ifdef FETCH_MISALIGN_FAULT_EN
        test_fault();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
